// File: rtl/thread_scheduler_pkg.sv
// Shared types and constants for the thread scheduler.
// Thread id, PC and thread-count definitions mirror the common package so the
// scheduler can be dropped into the pipeline without type conversions.
package thread_scheduler_pkg;

  localparam int N_THREADS    = 8;
  localparam int TID_W        = 3;
  localparam int n_threads    = N_THREADS;
  localparam int DRAIN_CYCLES = 8;

  localparam logic [31:0] RESET_PC   = 32'h0000_1000;
  localparam logic [31:0] EXC_VECTOR = 32'h0000_2000;

  typedef logic [TID_W-1:0] threadid_t;
  typedef logic [31:0]      vptr_t;
  typedef logic [7:0]       drain_cnt_t;

  typedef enum logic {
    RUN,
    DRAIN
  } sched_state_t;

endpackage

// File: rtl/thread_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter.
// Searches the request vector starting just after the last granted thread,
// wrapping modulo the thread count. The pointer register lives in the parent.
module thread_scheduler_rr_arbiter
  import thread_scheduler_pkg::*;
(
  input  logic [N_THREADS-1:0] i_req,
  input  threadid_t            i_last,
  output threadid_t            o_grant,
  output logic                 o_grant_valid
);

  threadid_t w_idx;

  // Walk last+1 .. last+N_THREADS; the id width makes the wrap free, and the
  // final step lands back on last itself so a lone requester still wins.
  always_comb begin
    o_grant       = '0;
    o_grant_valid = 1'b0;
    w_idx         = '0;
    for (int k = 1; k <= N_THREADS; k++) begin
      w_idx = i_last + threadid_t'(k);
      if (!o_grant_valid && i_req[w_idx]) begin
        o_grant       = w_idx;
        o_grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/thread_scheduler.sv
// Per-thread PC holder and round-robin fetch arbiter feeding the IF stage.
// Optional build macro THREAD_SCHED_PERF_EN adds per-thread issue counters on
// o_perf_issue_cnt; without it the port and counters do not exist.
module thread_scheduler
  import thread_scheduler_pkg::*;
(
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_if_ready,
  input  logic [N_THREADS-1:0]   i_stalled,
  input  logic [N_THREADS-1:0]   i_wb_pc_en,
  input  vptr_t                  i_wb_pc_data,
  input  logic                   i_exc_en,
  input  threadid_t              i_exc_thread,
  output logic                   o_if_valid,
  output threadid_t              o_if_thread,
  output vptr_t                  o_if_pc,
  output logic [N_THREADS*32-1:0] o_pc_all
`ifdef THREAD_SCHED_PERF_EN
  ,
  output logic [N_THREADS*32-1:0] o_perf_issue_cnt
`endif
);

  sched_state_t r_state     [N_THREADS];
  drain_cnt_t   r_drainCnt  [N_THREADS];
  sched_state_t w_stateNext [N_THREADS];
  drain_cnt_t   w_cntNext   [N_THREADS];
  vptr_t        r_pc        [N_THREADS];
  threadid_t    r_last;

  logic [N_THREADS-1:0] w_run;
  logic [N_THREADS-1:0] w_excHit;
  logic [N_THREADS-1:0] w_req;
  threadid_t            w_grant;
  logic                 w_grantValid;
  logic                 w_fire;

  // Decode which thread, if any, takes an exception this cycle.
  always_comb begin
    for (int i = 0; i < N_THREADS; i++) begin
      w_excHit[i] = i_exc_en && (i_exc_thread == threadid_t'(i));
    end
  end

  // Drain state register: exceptions park a thread while in-flight work drains.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < N_THREADS; i++) begin
        r_state[i]    <= RUN;
        r_drainCnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_THREADS; i++) begin
        r_state[i]    <= w_stateNext[i];
        r_drainCnt[i] <= w_cntNext[i];
      end
    end
  end

  // Next-state logic: a fresh exception always (re)loads the drain window.
  always_comb begin
    for (int i = 0; i < N_THREADS; i++) begin
      w_stateNext[i] = r_state[i];
      w_cntNext[i]   = r_drainCnt[i];
      if (w_excHit[i]) begin
        w_stateNext[i] = DRAIN;
        w_cntNext[i]   = drain_cnt_t'(DRAIN_CYCLES - 1);
      end else begin
        case (r_state[i])
          DRAIN: begin
            if (r_drainCnt[i] == '0) w_stateNext[i] = RUN;
            else                     w_cntNext[i]   = r_drainCnt[i] - 8'd1;
          end
          default: w_stateNext[i] = r_state[i];
        endcase
      end
    end
  end

  // State outputs: only RUN threads may compete for fetch.
  always_comb begin
    for (int i = 0; i < N_THREADS; i++) begin
      w_run[i] = (r_state[i] == RUN);
    end
  end

  // Eligibility excludes threads being redirected so a redirect never races an increment.
  always_comb begin
    w_req = w_run & ~i_stalled & ~i_wb_pc_en & ~w_excHit;
  end

  thread_scheduler_rr_arbiter u_arb (
    .i_req         (w_req),
    .i_last        (r_last),
    .o_grant       (w_grant),
    .o_grant_valid (w_grantValid)
  );

  assign w_fire = i_if_ready && w_grantValid;

  // PC registers: exception beats redirect beats speculative +4 advance.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < N_THREADS; i++) r_pc[i] <= RESET_PC;
    end else begin
      for (int i = 0; i < N_THREADS; i++) begin
        if (w_excHit[i])                                 r_pc[i] <= EXC_VECTOR;
        else if (i_wb_pc_en[i])                          r_pc[i] <= i_wb_pc_data;
        else if (w_fire && (w_grant == threadid_t'(i)))  r_pc[i] <= r_pc[i] + 32'd4;
      end
    end
  end

  // Registered fetch request and round-robin pointer; both hold when nothing fires.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_if_valid  <= 1'b0;
      o_if_thread <= '0;
      o_if_pc     <= RESET_PC;
      r_last      <= threadid_t'(N_THREADS - 1);
    end else if (w_fire) begin
      o_if_valid  <= 1'b1;
      o_if_thread <= w_grant;
      o_if_pc     <= r_pc[w_grant];
      r_last      <= w_grant;
    end else begin
      o_if_valid  <= 1'b0;
    end
  end

  for (genvar g = 0; g < N_THREADS; g++) begin : g_pcAll
    assign o_pc_all[32*g +: 32] = r_pc[g];
  end

`ifdef THREAD_SCHED_PERF_EN
  logic [31:0] r_perfCnt [N_THREADS];

  // Issue counters: one per thread, bumped on each grant, wrapping silently.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < N_THREADS; i++) r_perfCnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_THREADS; i++) begin
        if (w_fire && (w_grant == threadid_t'(i))) r_perfCnt[i] <= r_perfCnt[i] + 32'd1;
      end
    end
  end

  for (genvar g = 0; g < N_THREADS; g++) begin : g_perf
    assign o_perf_issue_cnt[32*g +: 32] = r_perfCnt[g];
  end
`endif

endmodule
